salida_leds: RTL and testbench

//  Avalon-MM slave output peripheral: HPS writes drive FPGA LED outputs (write-side counterpart of the switch input port).

---
 rtl/salida_pkg.sv | 25 ++
 rtl/salida_leds_if.sv | 19 +
 rtl/salida_prescaler.sv | 30 +++
 rtl/salida_leds.sv | 130 +++++++++++++
 tb/tb_salida_leds.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/salida_pkg.sv
// Shared constants for the LED output peripheral: register map,
// CTRL/STATUS bit positions and the blink FSM state encoding.
package salida_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int CTRL_CLR_IRQ = 0;
  localparam int CTRL_N_LSB   = 8;
  localparam int CTRL_START   = 16;
  localparam int CTRL_STOP    = 17;

  localparam int STAT_IRQ     = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_REM_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONT  = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

endpackage

// File: rtl/salida_leds_if.sv
// Avalon-MM slave bus bundle (address/write/read/data) plus the level IRQ.
interface salida_leds_if;
  logic [1:0]  avl_address;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic        avl_read;
  logic [31:0] avl_readdata;
  logic        avl_irq;

  modport master (
    output avl_address, avl_write, avl_writedata, avl_read,
    input  avl_readdata, avl_irq
  );

  modport slave (
    input  avl_address, avl_write, avl_writedata, avl_read,
    output avl_readdata, avl_irq
  );
endinterface

// File: rtl/salida_prescaler.sv
// Half-period prescaler: counts 0..period-1 while enabled and pulses tick
// on the terminal count. The >= compare lets a shrinking period take effect
// immediately instead of wrapping around the whole counter range.
module salida_prescaler #(
  parameter int PER_BITS = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                clr,
  input  logic [PER_BITS-1:0] period,
  output logic                tick
);

  logic [PER_BITS-1:0] cnt;

  assign tick = en && (cnt >= (period - PER_BITS'(1)));

  // Counter: held at zero when idle or cleared, restarts after each tick
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PER_BITS'(1);
    end
  end

endmodule

// File: rtl/salida_leds.sv
// LED output peripheral: static level register, per-bit blink mask,
// programmable half-period and a counted blink train that raises an IRQ
// when it completes.
module salida_leds
  import salida_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PER_BITS = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  salida_leds_if.slave     bus,
  output logic [WIDTH-1:0] leds
);

  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    mask;
  logic [PER_BITS-1:0] period;
  logic                phase;
  logic                irq;
  logic [7:0]          remaining;
  state_t              state;

  logic                ctrl_wr;
  logic                start;
  logic                stop;
  logic                clr_irq;
  logic [7:0]          n_req;
  logic                running;
  logic                tick;
  logic                done;
  logic [31:0]         rdata;

  // A stop in the same write overrides a start
  assign ctrl_wr = bus.avl_write && (bus.avl_address == ADDR_CTRL);
  assign stop    = ctrl_wr && bus.avl_writedata[CTRL_STOP];
  assign start   = ctrl_wr && bus.avl_writedata[CTRL_START] && !bus.avl_writedata[CTRL_STOP];
  assign clr_irq = ctrl_wr && bus.avl_writedata[CTRL_CLR_IRQ];
  assign n_req   = bus.avl_writedata[CTRL_N_LSB +: 8];
  assign running = (state != ST_IDLE);

  // A full on/off cycle ends on the low->high toggle; the last one completes the train
  assign done = (state == ST_COUNT) && tick && !phase && (remaining == 8'd1) && !start && !stop;

  salida_prescaler #(.PER_BITS(PER_BITS)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (running),
    .clr     (start || stop),
    .period  (period),
    .tick    (tick)
  );

  // Software-visible DATA/MASK/PERIOD registers; a zero period is stored as 1
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data   <= '0;
      mask   <= '0;
      period <= PER_BITS'(1);
    end else if (bus.avl_write) begin
      case (bus.avl_address)
        ADDR_DATA:   data <= bus.avl_writedata[WIDTH-1:0];
        ADDR_MASK:   mask <= bus.avl_writedata[WIDTH-1:0];
        ADDR_PERIOD: period <= (bus.avl_writedata[PER_BITS-1:0] == '0) ?
                               PER_BITS'(1) : bus.avl_writedata[PER_BITS-1:0];
        default:     ;
      endcase
    end
  end

  // Blink FSM with phase, remaining count and IRQ (set beats clear)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      phase     <= 1'b0;
      remaining <= 8'd0;
      irq       <= 1'b0;
    end else begin
      if (stop) begin
        state     <= ST_IDLE;
        phase     <= 1'b0;
        remaining <= 8'd0;
      end else if (start) begin
        phase     <= 1'b1;
        remaining <= n_req;
        state     <= (n_req == 8'd0) ? ST_CONT : ST_COUNT;
      end else if (tick) begin
        if (state == ST_COUNT && !phase) begin
          if (remaining == 8'd1) begin
            state     <= ST_IDLE;
            phase     <= 1'b0;
            remaining <= 8'd0;
          end else begin
            phase     <= 1'b1;
            remaining <= remaining - 8'd1;
          end
        end else begin
          phase <= !phase;
        end
      end
      if (done) begin
        irq <= 1'b1;
      end else if (clr_irq) begin
        irq <= 1'b0;
      end
    end
  end

  // Zero-latency read mux; idle bus reads as zero
  always_comb begin
    rdata = '0;
    if (bus.avl_read) begin
      case (bus.avl_address)
        ADDR_DATA:   rdata[WIDTH-1:0] = data;
        ADDR_MASK:   rdata[WIDTH-1:0] = mask;
        ADDR_PERIOD: rdata[PER_BITS-1:0] = period;
        default: begin
          rdata[STAT_IRQ]             = irq;
          rdata[STAT_BUSY]            = running;
          rdata[STAT_REM_LSB +: 8]    = remaining;
        end
      endcase
    end
  end

  assign bus.avl_readdata = rdata;
  assign bus.avl_irq      = irq;
  assign leds             = data ^ (mask & {WIDTH{phase}});

endmodule

// File: tb/tb_salida_leds.sv
// Bench for salida_leds: constant-expectation vector table, hand sequences
// for the multi-cycle corners, and random traffic against a train model.
module tb_salida_leds;

  logic       clk;
  logic       reset_n;
  logic [3:0] leds;
  int         checks;
  int         failures;

  salida_leds_if bus_if ();

  salida_leds #(.WIDTH(4), .PER_BITS(24)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .leds    (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a train is a number of half-periods still to run.
  logic [3:0] m_data, m_mask;
  int         m_period, m_age, m_halves;
  bit         m_phase, m_busy, m_counted, m_irq;

  task automatic m_reset();
    m_data = 0; m_mask = 0; m_period = 1; m_age = 0; m_halves = 0;
    m_phase = 0; m_busy = 0; m_counted = 0; m_irq = 0;
  endtask

  task automatic m_step(bit rn, bit w, logic [1:0] a, logic [31:0] d);
    bit tick, done, ctrl, stp, sta, clr;
    int n;
    if (!rn) begin
      m_reset();
      return;
    end
    tick = m_busy && (m_age + 1 >= m_period);
    done = 0;
    ctrl = w && (a == 2'd3);
    stp  = ctrl && d[17];
    sta  = ctrl && d[16] && !d[17];
    clr  = ctrl && d[0];
    if (stp) begin
      m_busy = 0; m_phase = 0; m_halves = 0; m_age = 0; m_counted = 0;
    end else if (sta) begin
      n = int'(d[15:8]);
      m_busy = 1; m_phase = 1; m_age = 0; m_counted = (n != 0); m_halves = 2 * n;
    end else if (m_busy) begin
      if (tick) begin
        m_age = 0;
        m_phase = !m_phase;
        if (m_counted) begin
          m_halves--;
          if (m_halves == 0) begin
            m_busy = 0; m_phase = 0; m_counted = 0; done = 1;
          end
        end
      end else begin
        m_age++;
      end
    end
    if (done) m_irq = 1;
    else if (clr) m_irq = 0;
    if (w) begin
      case (a)
        2'd0: m_data = d[3:0];
        2'd1: m_mask = d[3:0];
        2'd2: m_period = (d[23:0] == 0) ? 1 : int'(d[23:0]);
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] m_rd(logic [1:0] a);
    logic [31:0] r;
    int rem;
    r = 0;
    rem = m_counted ? (m_halves + 1) / 2 : 0;
    case (a)
      2'd0: r = {28'b0, m_data};
      2'd1: r = {28'b0, m_mask};
      2'd2: r = 32'(m_period);
      default: r = {16'b0, 8'(rem), 6'b0, m_busy, m_irq};
    endcase
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive, let the edge happen, advance model, compare after the edge
  task automatic step(bit rn, bit w, logic [1:0] a, logic [31:0] d, bit r, string tag);
    reset_n              = rn;
    bus_if.avl_write     = w;
    bus_if.avl_address   = a;
    bus_if.avl_writedata = d;
    bus_if.avl_read      = r;
    @(posedge clk);
    m_step(rn, w, a, d);
    #1;
    chk({tag, ":model_leds"}, {28'b0, leds}, {28'b0, m_data ^ (m_mask & {4{m_phase}})});
    chk({tag, ":model_irq"}, {31'b0, bus_if.avl_irq}, {31'b0, m_irq});
    if (r) chk({tag, ":model_rd"}, bus_if.avl_readdata, m_rd(a));
  endtask

  typedef struct {
    bit          rn;
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    bit          rd;
    logic [3:0]  e_leds;
    bit          e_irq;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mk(bit rn, bit wr, logic [1:0] addr, logic [31:0] wd, bit rd,
                              logic [3:0] e_leds, bit e_irq, logic [31:0] e_rd);
    vec_t v;
    v.rn = rn; v.wr = wr; v.addr = addr; v.wd = wd; v.rd = rd;
    v.e_leds = e_leds; v.e_irq = e_irq; v.e_rd = e_rd;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    string tg;
    int r;
    logic [31:0] d;
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    bus_if.avl_write = 0; bus_if.avl_read = 0;
    bus_if.avl_address = 0; bus_if.avl_writedata = 0;
    m_reset();

    // Reset with writes active, reset values, static level, counted train
    tbl.push_back(mk(0, 1, 2'd0, 32'hF, 0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 1, 2'd3, 32'h0001_0300, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 2'd0, 0, 1, 4'h0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2'd1, 0, 1, 4'h0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2'd2, 0, 1, 4'h0, 0, 32'h1));
    tbl.push_back(mk(1, 0, 2'd3, 0, 1, 4'h0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 2'd0, 32'hFFFF_FFFA, 0, 4'hA, 0, 0));
    tbl.push_back(mk(1, 1, 2'd1, 32'h0, 0, 4'hA, 0, 0));
    tbl.push_back(mk(1, 0, 2'd3, 0, 1, 4'hA, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2'd0, 0, 1, 4'hA, 0, 32'hA));
    tbl.push_back(mk(1, 1, 2'd0, 32'h0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 1, 2'd2, 32'h4, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 1, 2'd1, 32'h1, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 1, 2'd3, 32'h0001_0200, 0, 4'h1, 0, 0));
    for (int k = 2; k <= 17; k++) begin
      tbl.push_back(mk(1, 0, 2'd3, 0, 1,
                       (k <= 16 && (((k - 1) >> 2) & 1) == 0) ? 4'h1 : 4'h0,
                       (k == 17),
                       (k <= 8) ? 32'h0202 : (k <= 16) ? 32'h0102 : 32'h0001));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      tg = $sformatf("tbl[%0d]", i);
      step(v.rn, v.wr, v.addr, v.wd, v.rd, tg);
      chk({tg, ":leds"}, {28'b0, leds}, {28'b0, v.e_leds});
      chk({tg, ":irq"}, {31'b0, bus_if.avl_irq}, {31'b0, v.e_irq});
      if (v.rd) chk({tg, ":rd"}, bus_if.avl_readdata, v.e_rd);
    end

    // IRQ clear racing completion: set wins, later clear works
    step(1, 1, 2'd3, 32'h1, 0, "race_pre");
    chk("race_pre_clr", {31'b0, bus_if.avl_irq}, 32'h0);
    step(1, 1, 2'd2, 32'h1, 0, "race_per");
    step(1, 1, 2'd3, 32'h0001_0100, 0, "race_start");
    step(1, 0, 2'd0, 0, 0, "race_low");
    step(1, 1, 2'd3, 32'h1, 0, "race_clr");
    chk("race_set_wins", {31'b0, bus_if.avl_irq}, 32'h1);
    step(1, 0, 2'd3, 0, 1, "race_idle");
    chk("race_status", bus_if.avl_readdata, 32'h1);
    step(1, 1, 2'd3, 32'h1, 0, "race_clr2");
    chk("race_cleared", {31'b0, bus_if.avl_irq}, 32'h0);

    // Continuous blink with zero period, then stop (stop beats start)
    step(1, 1, 2'd2, 32'h0, 0, "cont_per0");
    step(1, 0, 2'd2, 0, 1, "cont_rdper");
    chk("cont_per_reads_1", bus_if.avl_readdata, 32'h1);
    step(1, 1, 2'd1, 32'hF, 0, "cont_mask");
    step(1, 1, 2'd3, 32'h0001_0000, 0, "cont_start");
    chk("cont_first", {28'b0, leds}, 32'hF);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 2'd0, 0, 0, "cont_run");
      chk($sformatf("cont_toggle%0d", k), {28'b0, leds}, (k % 2 == 0) ? 32'h0 : 32'hF);
    end
    step(1, 1, 2'd3, 32'h0003_0400, 0, "cont_stop");
    chk("cont_stop_leds", {28'b0, leds}, 32'h0);
    step(1, 0, 2'd3, 0, 1, "cont_stat");
    chk("cont_stop_status", bus_if.avl_readdata, 32'h0);

    // Mid-run period decrease takes effect without wrap-around
    step(1, 1, 2'd2, 32'h8, 0, "mid_per8");
    step(1, 1, 2'd3, 32'h0001_0300, 0, "mid_start");
    for (int k = 1; k <= 5; k++) step(1, 0, 2'd0, 0, 0, "mid_run");
    chk("mid_before", {28'b0, leds}, 32'hF);
    step(1, 1, 2'd2, 32'h2, 0, "mid_per2");
    chk("mid_still_high", {28'b0, leds}, 32'hF);
    step(1, 0, 2'd0, 0, 0, "mid_toggle");
    chk("mid_toggled", {28'b0, leds}, 32'h0);
    step(1, 0, 2'd0, 0, 0, "mid_run2");

    // Reset in the middle of a counted train
    step(0, 0, 2'd0, 0, 0, "mid_reset");
    chk("mid_reset_leds", {28'b0, leds}, 32'h0);
    chk("mid_reset_irq", {31'b0, bus_if.avl_irq}, 32'h0);
    step(1, 0, 2'd3, 0, 1, "mid_rst_stat");
    chk("mid_reset_status", bus_if.avl_readdata, 32'h0);
    step(1, 0, 2'd2, 0, 1, "mid_rst_per");
    chk("mid_reset_period", bus_if.avl_readdata, 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      d = $urandom;
      tg = $sformatf("rnd[%0d]", i);
      if (r < 2) begin
        step(0, 1, 2'($urandom_range(0, 3)), d, 0, tg);
      end else if (r < 14) begin
        step(1, 1, 2'd0, d, $urandom_range(0, 1) == 1, tg);
      end else if (r < 24) begin
        step(1, 1, 2'd1, d, $urandom_range(0, 1) == 1, tg);
      end else if (r < 32) begin
        step(1, 1, 2'd2, {d[31:24], 24'($urandom_range(0, 4))}, 0, tg);
      end else if (r < 44) begin
        d[15:8] = 8'($urandom_range(0, 3));
        d[16] = ($urandom_range(0, 2) != 0);
        d[17] = ($urandom_range(0, 9) == 0);
        step(1, 1, 2'd3, d, $urandom_range(0, 1) == 1, tg);
      end else begin
        step(1, 0, 2'($urandom_range(0, 3)), d, $urandom_range(0, 3) != 0, tg);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
